id_inbuf: RTL and testbench

Instruction input buffer at the receiving end of the IF-to-ID handshake. Accepts `{pc, inst}` packets from the fetch unit when `IF_to_ID_Valid` is high and the block's own `ID_Allow_in` is high. Queues them in a small circular FIFO and presents them one at a time to the decode logic under a valid/ready handshake. A taken branch on `br_bus` discards every queued packet and the packet arriving that cycle, since all of them are wrong-path instructions.

---
 rtl/id_inbuf.sv | 124 ++++++++++++
 tb/tb_id_inbuf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_inbuf.sv
// -----------------------------------------------------------------------------
// id_inbuf
//
// Instruction input buffer at the receiving end of the IF-to-ID handshake.
// {pc, inst} packets from fetch are queued in a small circular FIFO and handed
// to decode one at a time under a valid/ready handshake. A taken branch
// discards everything queued plus the packet arriving in the same cycle,
// because all of them are wrong-path instructions.
//
// Parameters:
//   DEPTH  number of buffered packets (power of two, >= 2)
//   BUS_W  packet width, {pc[31:0], inst[31:0]} with pc in the upper half
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   IF_to_ID_Bus      packet from fetch
//   IF_to_ID_Valid    packet valid
//   ID_Allow_in       buffer can accept a packet this cycle (registered state only)
//   br_bus            {br_taken, br_target}; only br_taken is used
//   dec_valid         head packet available
//   dec_pc, dec_inst  head packet fields, zero while dec_valid is low
//   dec_ready         decoder consumes the head packet this cycle
//   flush_drop_cnt    packets discarded by flushes
//
// Optional feature: define ID_INBUF_STAT_EN to build the flush drop counter;
// without it flush_drop_cnt is tied to 0.
// -----------------------------------------------------------------------------
module id_inbuf #(
    parameter int DEPTH = 2,
    parameter int BUS_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] IF_to_ID_Bus,
    input  logic             IF_to_ID_Valid,
    output logic             ID_Allow_in,
    input  logic [32:0]      br_bus,
    output logic             dec_valid,
    output logic [31:0]      dec_pc,
    output logic [31:0]      dec_inst,
    input  logic             dec_ready,
    output logic [31:0]      flush_drop_cnt
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [BUS_W-1:0] head;

    logic flush;
    logic push;
    logic pop;

    // Branch target is consumed elsewhere; only the taken bit matters here.
    wire unused_br_target = ^br_bus[31:0];

    assign flush = br_bus[32];

    // Allow-in looks only at registered occupancy, so a full buffer refuses a
    // packet even when decode drains an entry in the same cycle.
    assign ID_Allow_in = (count != FULL_CNT);
    assign dec_valid   = (count != '0);

    assign push = IF_to_ID_Valid & ID_Allow_in & ~flush;
    assign pop  = dec_valid & dec_ready & ~flush;

    assign head     = mem[rd_ptr];
    assign dec_pc   = dec_valid ? head[BUS_W-1 -: 32] : 32'h0;
    assign dec_inst = dec_valid ? head[31:0]          : 32'h0;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // NOTE: storage has no reset; stale entries are masked by dec_valid, which
    // keeps the array free of reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= IF_to_ID_Bus;
    end

`ifdef ID_INBUF_STAT_EN
    // Counts the queued packets plus the one arriving in the flush cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_drop_cnt <= 32'h0;
        end else if (flush) begin
            flush_drop_cnt <= flush_drop_cnt + 32'(count) + 32'(IF_to_ID_Valid);
        end
    end
`else
    assign flush_drop_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_inbuf.sv
// -----------------------------------------------------------------------------
// tb_id_inbuf
//
// Self-checking bench for id_inbuf. A queue-based reference model tracks the
// buffered packets; directed sequences cover reset, fill/drain, streaming,
// flush with an incoming packet and asynchronous reset, followed by a long
// randomized run.
// -----------------------------------------------------------------------------
module tb_id_inbuf;

    localparam int DEPTH = 2;
    localparam int BUS_W = 64;

    logic             clk;
    logic             reset;
    logic [BUS_W-1:0] IF_to_ID_Bus;
    logic             IF_to_ID_Valid;
    logic             ID_Allow_in;
    logic [32:0]      br_bus;
    logic             dec_valid;
    logic [31:0]      dec_pc;
    logic [31:0]      dec_inst;
    logic             dec_ready;
    logic [31:0]      flush_drop_cnt;

    id_inbuf #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_to_ID_Bus   (IF_to_ID_Bus),
        .IF_to_ID_Valid (IF_to_ID_Valid),
        .ID_Allow_in    (ID_Allow_in),
        .br_bus         (br_bus),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_inst       (dec_inst),
        .dec_ready      (dec_ready),
        .flush_drop_cnt (flush_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packets in arrival order plus expected drop count.
    logic [63:0] q[$];
    logic [31:0] exp_drops = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        logic [63:0] h;
        h = (q.size() != 0) ? q[0] : 64'h0;
        check("dec_valid",      64'(dec_valid),      64'(q.size() != 0));
        check("dec_pc",         64'(dec_pc),         64'(h[63:32]));
        check("dec_inst",       64'(dec_inst),       64'(h[31:0]));
        check("ID_Allow_in",    64'(ID_Allow_in),    64'(q.size() < DEPTH));
        check("flush_drop_cnt", 64'(flush_drop_cnt), 64'(exp_drops));
    endtask

    // Drives one cycle's inputs at edge+1, checks the current outputs against
    // the model, clocks, then advances the model by the same rules.
    task automatic do_cycle(input logic v, input logic [63:0] b, input logic r, input logic f);
        logic acc;
        logic rd;
        IF_to_ID_Valid = v;
        IF_to_ID_Bus   = b;
        dec_ready      = r;
        br_bus         = {f, 32'h1c000100};
        compare_model();
        acc = v && (q.size() < DEPTH);
        rd  = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (f) begin
`ifdef ID_INBUF_STAT_EN
            exp_drops += 32'(q.size()) + 32'(v);
`endif
            q.delete();
        end else begin
            if (rd)  void'(q.pop_front());
            if (acc) q.push_back(b);
        end
    endtask

    function automatic logic [63:0] pkt(input logic [31:0] pc);
        return {pc, $urandom()};
    endfunction

    logic [31:0] drops_before;

    initial begin
        reset          = 1'b1;
        IF_to_ID_Bus   = '0;
        IF_to_ID_Valid = 1'b0;
        br_bus         = '0;
        dec_ready      = 1'b0;

        // Reset state, before any clock edge.
        #2;
        compare_model();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single packet, no bypass, visible after the push edge.
        do_cycle(1'b1, {32'h1c000000, 32'h02800c0c}, 1'b0, 1'b0);
        check("t1_valid", 64'(dec_valid),   64'd1);
        check("t1_pc",    64'(dec_pc),      64'h1c000000);
        check("t1_inst",  64'(dec_inst),    64'h02800c0c);
        check("t1_allow", 64'(ID_Allow_in), 64'd1);

        // Empty out, then fill to full; third packet must be refused.
        do_cycle(1'b0, 64'h0, 1'b0, 1'b1);
        do_cycle(1'b1, pkt(32'h1c000000), 1'b0, 1'b0);
        do_cycle(1'b1, pkt(32'h1c000004), 1'b0, 1'b0);
        check("t2_full_allow", 64'(ID_Allow_in), 64'd0);
        do_cycle(1'b1, pkt(32'h1c000008), 1'b0, 1'b0);
        check("t2_head_pc", 64'(dec_pc), 64'h1c000000);
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("t2_second_pc", 64'(dec_pc), 64'h1c000004);
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("t2_drained", 64'(dec_valid), 64'd0);

        // Full with pop in the same cycle: push deferred one cycle.
        do_cycle(1'b1, pkt(32'h1c000010), 1'b0, 1'b0);
        do_cycle(1'b1, pkt(32'h1c000014), 1'b0, 1'b0);
        do_cycle(1'b1, pkt(32'h1c000018), 1'b1, 1'b0);
        do_cycle(1'b1, pkt(32'h1c000018), 1'b1, 1'b0);
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Streaming with dec_ready held high, crossing pointer wrap repeatedly.
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, pkt(32'h1c000000 + 32'(4 * k)), 1'b1, 1'b0);
            check("t3_stream_pc", 64'(dec_pc), 64'(32'h1c000000 + 32'(4 * k)));
        end
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Flush together with an incoming packet: three packets dropped.
        do_cycle(1'b1, pkt(32'h1c000020), 1'b0, 1'b0);
        do_cycle(1'b1, pkt(32'h1c000024), 1'b0, 1'b0);
        drops_before = exp_drops;
        do_cycle(1'b1, pkt(32'h1c000028), 1'b0, 1'b1);
        check("t4_valid", 64'(dec_valid),   64'd0);
        check("t4_allow", 64'(ID_Allow_in), 64'd1);
`ifdef ID_INBUF_STAT_EN
        check("t4_drops", 64'(flush_drop_cnt), 64'(drops_before + 32'd3));
`else
        check("t4_drops", 64'(flush_drop_cnt), 64'(drops_before));
`endif

        // Asynchronous reset between edges with one packet queued.
        do_cycle(1'b1, pkt(32'h1c000030), 1'b0, 1'b0);
        IF_to_ID_Valid = 1'b0;
        dec_ready      = 1'b0;
        br_bus         = '0;
        #3;
        reset = 1'b1;
        #1;
        check("t5_async_valid", 64'(dec_valid),      64'd0);
        check("t5_async_allow", 64'(ID_Allow_in),    64'd1);
        check("t5_async_drops", 64'(flush_drop_cnt), 64'd0);
        q.delete();
        exp_drops = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_cycle(1'b1, {32'h1c000040, 32'h0badf00d}, 1'b0, 1'b0);
        check("t5_after_pc",   64'(dec_pc),   64'h1c000040);
        check("t5_after_inst", 64'(dec_inst), 64'h0badf00d);
        do_cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            do_cycle(1'($urandom_range(0, 3) != 0),
                     {$urandom(), $urandom()},
                     1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 11) == 0));
        end
        compare_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
